// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. One transaction is in flight at a time:
//   IDLE (grant) -> SERVE_IF/SERVE_D (wait for mem_ack or timeout) -> RESP
//   (one-cycle done pulse) -> IDLE.
//
//   Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   : ties go to the requester not served last (pointer resets
//                 to "fetch served last", so the first tie goes to data).
//     undefined : data always wins a tie.
//
// Ports
//   clock, reset           sole clock; synchronous active-high reset
//   if_req/if_addr         fetch request (held until if_gnt) and address
//   if_gnt/if_done         one-cycle fetch grant / completion
//   if_rdata               last fetched instruction word
//   d_req/d_we/d_size/     data request (held until d_gnt), store enable,
//   d_addr/d_wdata         size code, address, store data
//   d_gnt/d_done/d_rdata   one-cycle data grant / completion, last load data
//   err                    qualifies a done pulse: transaction timed out
//   mem_req/mem_we/        memory request (held until mem_ack), write enable,
//   mem_size/mem_addr/     size code, address, write data
//   mem_wdata
//   mem_rdata/mem_ack      memory read data and completion strobe
//   busy                   high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D, RESP} state_t;

  // The wait counter times out on its last permitted cycle, so mem_req is
  // high for exactly TIMEOUT cycles when no ack arrives.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;    // 1 = data side owns the transaction
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;              // data side wins arbitration

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q;                      // 1 = data was served last

  // On a tie, serve whoever was not served last.
  always_comb pick_d = d_req && (!if_req || !last_data_q);

  always_ff @(posedge clock) begin
    if (reset)
      last_data_q <= 1'b0;
    else if (if_gnt || d_gnt)
      last_data_q <= d_gnt;
  end
`else
  always_comb pick_d = d_req;
`endif

  // NOTE: every combinational output and next-state value gets a default
  // before the case statement; a path that skips an assignment would
  // otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    err_d      = err_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_done    = 1'b0;
    d_done     = 1'b0;
    err        = 1'b0;
    mem_req    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so every output is 0.
        if ((if_req || d_req) && !reset) begin
          owner_d = pick_d;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (pick_d) begin
            d_gnt   = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            size_d  = d_size;
            wdata_d = d_wdata;
            state_d = SERVE_D;
          end else begin
            if_gnt  = 1'b1;
            addr_d  = if_addr;
            we_d    = 1'b0;
            size_d  = 2'b10;
            wdata_d = '0;
            state_d = SERVE_IF;
          end
        end
      end
      SERVE_IF, SERVE_D: begin
        mem_req = 1'b1;
        // An ack on the final wait cycle takes priority over the timeout.
        if (mem_ack) begin
          if (state_q == SERVE_D) d_rdata_d  = mem_rdata;
          else                    if_rdata_d = mem_rdata[31:0];
          state_d = RESP;
        end else if (cnt_q == LAST_WAIT) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if_done = !owner_q;
        d_done  = owner_q;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the read-data holding registers are reset too, because their
  // outputs are required to read 0 out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (ADDR_W=64, DATA_W=64, TIMEOUT=4).
//   The bench plays both requesters and the memory. A transaction-level
//   reference (who should win, what the memory should see, when done arrives,
//   whether it is an error, what rdata should hold) predicts every check.
//   Honours MEM_ARB_ROUND_ROBIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_done;
  logic [31:0]   if_rdata;
  logic          d_req, d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_done;
  logic [DW-1:0] d_rdata;
  logic          err, mem_req, mem_we;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack, busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit          last_d_m;     // data side was served last
  logic [31:0] m_if_rdata;
  logic [63:0] m_d_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled at the following falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = {$urandom, $urandom};
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_size  = 2'($urandom_range(0, 3));
    d_addr  = {$urandom, $urandom};
    d_wdata = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    step();
    @(negedge clock);
    check("rst_mem_req", mem_req, 0);
    check("rst_gnt", {if_gnt, d_gnt}, 0);
    check("rst_done_err", {if_done, d_done, err}, 0);
    check("rst_busy", busy, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_fields", {mem_we, mem_size}, 0);
    check("rst_mem_addr", mem_addr, 0);
    step();
    reset      = 1'b0;
    last_d_m   = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
  endtask

  // One transaction, entered just after a rising edge with the arbiter idle
  // and the requests already driven. w = wait cycle carrying mem_ack
  // (w >= TO means memory never answers).
  task automatic run_txn(input int w, input logic [63:0] ack_val, output bit got_d);
    bit          exp_d, acked;
    logic [63:0] e_addr;
    logic [1:0]  e_size;
    bit          e_we;
    if (if_req && d_req) exp_d = RR ? !last_d_m : 1'b1;
    else                 exp_d = d_req;
    e_addr = exp_d ? d_addr : if_addr;
    e_we   = exp_d ? d_we : 1'b0;
    e_size = exp_d ? d_size : 2'b10;
    // A stray ack while idle must be ignored.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = {$urandom, $urandom};
    @(negedge clock);
    got_d = d_gnt;
    check("gnt_if", if_gnt, !exp_d);
    check("gnt_d", d_gnt, exp_d);
    check("idle_busy", busy, 0);
    check("idle_done", {if_done, d_done, err}, 0);
    check("idle_if_rdata", if_rdata, m_if_rdata);
    check("idle_d_rdata", d_rdata, m_d_rdata);
    last_d_m = exp_d;
    acked    = 1'b0;
    for (int k = 0; k < TO; k++) begin
      step();
      if (k == 0) begin
        if (exp_d) d_req = 1'b0;
        else       if_req = 1'b0;
      end
      mem_ack   = (k == w);
      mem_rdata = (k == w) ? ack_val : {$urandom, $urandom};
      @(negedge clock);
      check("serve_mem_req", mem_req, 1);
      check("serve_addr", mem_addr, e_addr);
      check("serve_we", mem_we, e_we);
      check("serve_size", mem_size, e_size);
      if (exp_d) check("serve_wdata", mem_wdata, d_wdata);
      check("serve_busy", busy, 1);
      check("serve_gnt", {if_gnt, d_gnt}, 0);
      check("serve_done", {if_done, d_done, err}, 0);
      if (k == w) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      if (exp_d) m_d_rdata = ack_val;
      else       m_if_rdata = ack_val[31:0];
    end
    step();
    // A stray ack during the response cycle must not be captured.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = {$urandom, $urandom};
    @(negedge clock);
    check("resp_if_done", if_done, !exp_d);
    check("resp_d_done", d_done, exp_d);
    check("resp_err", err, !acked);
    check("resp_mem_req", mem_req, 0);
    check("resp_busy", busy, 1);
    check("resp_gnt", {if_gnt, d_gnt}, 0);
    check("resp_if_rdata", if_rdata, m_if_rdata);
    check("resp_d_rdata", d_rdata, m_d_rdata);
    step();
    mem_ack = 1'b0;
  endtask

  bit got;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    do_reset();

    // Both requesters held for four transactions from reset.
    new_if();
    new_d();
    for (int i = 0; i < 4; i++) begin
      run_txn($urandom_range(0, TO - 1), {$urandom, $urandom}, got);
      check("tie_seq", got, RR ? ((i % 2) == 0) : 1'b1);
      if (got) new_d();
      else     new_if();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    step();

    // Single fetch at 0x40, ack on the third wait cycle.
    if_req  = 1'b1;
    if_addr = 64'h40;
    run_txn(2, 64'h8B020041, got);
    check("fetch_rdata", if_rdata, 64'h8B020041);

    // Double-word store, ack on the second wait cycle.
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b11;
    d_addr = 64'h100; d_wdata = 64'hDEADBEEF;
    run_txn(1, {$urandom, $urandom}, got);

    // Timeouts: no ack, then ack on the last permitted cycle.
    new_d();
    d_we = 1'b0;
    run_txn(TO, {$urandom, $urandom}, got);
    new_if();
    run_txn(TO, {$urandom, $urandom}, got);
    new_d();
    run_txn(TO - 1, {$urandom, $urandom}, got);
    new_if();
    run_txn(TO - 1, {$urandom, $urandom}, got);

    // Stray ack with nothing requested.
    mem_ack   = 1'b1;
    mem_rdata = 64'h1234;
    @(negedge clock);
    check("stray_gnt", {if_gnt, d_gnt}, 0);
    step();
    mem_ack = 1'b0;
    @(negedge clock);
    check("stray_done", {if_done, d_done, err}, 0);
    check("stray_busy", busy, 0);
    check("stray_if_rdata", if_rdata, m_if_rdata);
    check("stray_d_rdata", d_rdata, m_d_rdata);
    step();

    // Reset during a data wait; the held request is granted again afterwards.
    new_d();
    @(negedge clock);
    check("abort_gnt", d_gnt, 1);
    step();
    @(negedge clock);
    check("abort_serving", mem_req, 1);
    step();
    do_reset();
    run_txn($urandom_range(0, TO), {$urandom, $urandom}, got);
    check("regrant_after_reset", got, 1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if (!if_req && $urandom_range(0, 1) == 1) new_if();
      if (!d_req && $urandom_range(0, 1) == 1) new_d();
      if (!if_req && !d_req) begin
        if ($urandom_range(0, 1) == 1) new_if();
        else                           new_d();
      end
      run_txn($urandom_range(0, TO), {$urandom, $urandom}, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
